// File: rtl/alu_result_accumulator_if.sv
// Valid/ready bundle between the ALU stage, the accumulator and the batch
// record consumer. The slave modport is the accumulator's view.
interface alu_result_accumulator_if #(
  parameter int WIDTH     = 3,
  parameter int N_ACC     = 4,
  parameter int ACC_WIDTH = 8
) ();
  localparam int CW = $clog2(N_ACC + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_result;
  logic                 in_cout;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [CW-1:0]        out_carries;
  logic [CW-1:0]        out_count;
  logic                 out_overflow;

  modport master (
    output in_valid, in_result, in_cout, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_carries, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_result, in_cout, flush, out_ready,
    output in_ready, out_valid, out_sum, out_carries, out_count, out_overflow
  );
endinterface

// File: rtl/alu_result_accumulator.sv
// Sums N_ACC ALU results (or fewer, on flush) into a wider accumulator, counts
// carry-outs and beats, and presents one registered batch record per batch.
module alu_result_accumulator #(
  parameter int WIDTH     = 3,
  parameter int N_ACC     = 4,
  parameter int ACC_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  alu_result_accumulator_if.slave bus
);
  localparam int CW = $clog2(N_ACC + 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t               state;
  state_t               state_next;

  logic [ACC_WIDTH-1:0] acc;
  logic [CW-1:0]        carries;
  logic [CW-1:0]        count;
  logic                 overflow;

  logic [ACC_WIDTH-1:0] out_sum_q;
  logic [CW-1:0]        out_carries_q;
  logic [CW-1:0]        out_count_q;
  logic                 out_overflow_q;

  logic                 accept;
  logic                 close;
  logic [ACC_WIDTH:0]   sum_ext;
  logic [ACC_WIDTH-1:0] acc_new;
  logic [CW-1:0]        carries_new;
  logic [CW-1:0]        count_new;
  logic                 overflow_new;

  // Post-update totals for this cycle, batch-close decision and next state
  always_comb begin
    state_next   = state;
    accept       = (state == ACCUM) && bus.in_valid;
    sum_ext      = {1'b0, acc} + (ACC_WIDTH + 1)'(bus.in_result);
    acc_new      = accept ? sum_ext[ACC_WIDTH-1:0] : acc;
    overflow_new = overflow | (accept & sum_ext[ACC_WIDTH]);
    carries_new  = carries + CW'(accept & bus.in_cout);
    count_new    = count + CW'(accept);
    close        = (state == ACCUM) &&
                   ((accept && (count_new == CW'(N_ACC))) ||
                    (bus.flush && (count_new != '0)));
    case (state)
      ACCUM: if (close) state_next = HOLD;
      HOLD:  if (bus.out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  // Running totals clear when a batch closes; the record registers load them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc            <= '0;
      carries        <= '0;
      count          <= '0;
      overflow       <= 1'b0;
      out_sum_q      <= '0;
      out_carries_q  <= '0;
      out_count_q    <= '0;
      out_overflow_q <= 1'b0;
    end else if (close) begin
      acc            <= '0;
      carries        <= '0;
      count          <= '0;
      overflow       <= 1'b0;
      out_sum_q      <= acc_new;
      out_carries_q  <= carries_new;
      out_count_q    <= count_new;
      out_overflow_q <= overflow_new;
    end else begin
      acc            <= acc_new;
      carries        <= carries_new;
      count          <= count_new;
      overflow       <= overflow_new;
    end
  end

  assign bus.in_ready     = (state == ACCUM);
  assign bus.out_valid    = (state == HOLD);
  assign bus.out_sum      = out_sum_q;
  assign bus.out_carries  = out_carries_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_overflow = out_overflow_q;
endmodule

// File: tb/tb_alu_result_accumulator.sv
// Bench for alu_result_accumulator: an 8-bit and a 4-bit accumulator share the
// same stimulus; a queue-based batch model predicts handshakes and records.
module tb_alu_result_accumulator;
  localparam int N_ACC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  // Model state: beats of the open batch, whether a record is pending, and it
  int   res_q[$];
  int   cout_q[$];
  bit   m_hold = 0;
  int   e_count, e_carries, e_sum8, e_sum4, e_ovf8, e_ovf4;

  alu_result_accumulator_if #(.WIDTH(3), .N_ACC(N_ACC), .ACC_WIDTH(8)) b8 ();
  alu_result_accumulator_if #(.WIDTH(3), .N_ACC(N_ACC), .ACC_WIDTH(4)) b4 ();

  alu_result_accumulator #(.WIDTH(3), .N_ACC(N_ACC), .ACC_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8)
  );
  alu_result_accumulator #(.WIDTH(3), .N_ACC(N_ACC), .ACC_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic driveInputs(input logic v, input logic [2:0] r, input logic c,
                             input logic f, input logic ordy);
    b8.in_valid = v; b8.in_result = r; b8.in_cout = c; b8.flush = f; b8.out_ready = ordy;
    b4.in_valid = v; b4.in_result = r; b4.in_cout = c; b4.flush = f; b4.out_ready = ordy;
  endtask

  // Batch-level model: a batch closes when it holds N_ACC beats or is flushed non-empty
  task automatic modelStep(input logic v, input logic [2:0] r, input logic c,
                           input logic f, input logic ordy);
    int tot;
    if (!m_hold) begin
      if (v) begin
        res_q.push_back(int'(r));
        cout_q.push_back(int'(c));
      end
      if (res_q.size() == N_ACC || (f && res_q.size() > 0)) begin
        tot = 0;
        e_carries = 0;
        foreach (res_q[i]) tot += res_q[i];
        foreach (cout_q[i]) e_carries += cout_q[i];
        e_count = res_q.size();
        e_sum8  = tot % 256;
        e_ovf8  = (tot > 255) ? 1 : 0;
        e_sum4  = tot % 16;
        e_ovf4  = (tot > 15) ? 1 : 0;
        res_q.delete();
        cout_q.delete();
        m_hold = 1;
      end
    end else if (ordy) begin
      m_hold = 0;
    end
  endtask

  task automatic checkOutput();
    checkVal("in_ready8", b8.in_ready, m_hold ? 0 : 1);
    checkVal("in_ready4", b4.in_ready, m_hold ? 0 : 1);
    checkVal("out_valid8", b8.out_valid, m_hold ? 1 : 0);
    checkVal("out_valid4", b4.out_valid, m_hold ? 1 : 0);
    if (m_hold) begin
      checkVal("sum8", b8.out_sum, e_sum8);
      checkVal("ovf8", b8.out_overflow, e_ovf8);
      checkVal("count8", b8.out_count, e_count);
      checkVal("carries8", b8.out_carries, e_carries);
      checkVal("sum4", b4.out_sum, e_sum4);
      checkVal("ovf4", b4.out_overflow, e_ovf4);
      checkVal("count4", b4.out_count, e_count);
      checkVal("carries4", b4.out_carries, e_carries);
    end
  endtask

  // One clock: drive, advance the model across the edge, check 1 time unit later
  task automatic applyStimulus(input logic v, input logic [2:0] r, input logic c,
                               input logic f, input logic ordy);
    driveInputs(v, r, c, f, ordy);
    @(posedge clk);
    modelStep(v, r, c, f, ordy);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    driveInputs(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    res_q.delete();
    cout_q.delete();
    m_hold = 0;
    #1;
    rst_n = 1'b1;
    checkVal("rst_valid", b8.out_valid, 0);
    checkVal("rst_ready", b8.in_ready, 1);
    checkVal("rst_sum", b8.out_sum, 0);
    checkVal("rst_carries", b8.out_carries, 0);
    checkVal("rst_count", b8.out_count, 0);
    checkVal("rst_ovf", b8.out_overflow, 0);
    checkVal("rst_sum4", b4.out_sum, 0);
  endtask

  initial begin
    driveInputs(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    doReset();

    $display("[TB] full batch, out_ready high");
    applyStimulus(1, 3, 0, 0, 1);
    applyStimulus(1, 5, 1, 0, 1);
    applyStimulus(1, 7, 1, 0, 1);
    applyStimulus(1, 1, 0, 0, 1);
    checkVal("t1_sum", b8.out_sum, 16);
    checkVal("t1_carries", b8.out_carries, 2);
    checkVal("t1_count", b8.out_count, 4);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] full batch, out_ready held low");
    applyStimulus(1, 3, 0, 0, 0);
    applyStimulus(1, 5, 1, 0, 0);
    applyStimulus(1, 7, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 2, 1, 0, 0);
    applyStimulus(1, 2, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] overflow in narrow accumulator");
    for (int i = 0; i < 4; i++) applyStimulus(1, 7, 0, 0, 0);
    checkVal("t3_sum4", b4.out_sum, 12);
    checkVal("t3_ovf4", b4.out_overflow, 1);
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 0);
    checkVal("t3b_sum4", b4.out_sum, 4);
    checkVal("t3b_ovf4", b4.out_overflow, 0);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] flush cases");
    applyStimulus(1, 2, 0, 0, 0);
    applyStimulus(1, 3, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkVal("t4_sum", b8.out_sum, 5);
    checkVal("t4_count", b8.out_count, 2);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] flush with accept");
    applyStimulus(1, 4, 0, 0, 0);
    applyStimulus(1, 6, 0, 1, 0);
    checkVal("t5_sum", b8.out_sum, 10);
    checkVal("t5_count", b8.out_count, 2);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] reset mid-batch");
    applyStimulus(1, 5, 0, 0, 1);
    applyStimulus(1, 5, 0, 0, 1);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 0);
    checkVal("t6_sum", b8.out_sum, 4);
    checkVal("t6_count", b8.out_count, 4);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
